// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//
// UART receive front end feeding the instruction-memory loader. It does four things:
//   - Synchronises the raw RX line.
//   - Oversamples it at 16x baud.
//   - Deframes 8N1 bytes, LSB first.
//   - Hands each good byte to the consumer through a sticky ready flag.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         raw asynchronous serial line, idles high
//   rdy_clr    one-cycle pulse from the consumer, clears rdy and overrun
//   dout[7:0]  last correctly received byte
//   rdy        byte available on dout, sticky until rdy_clr
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky, a byte completed while rdy was still set
//   busy       receiver is anywhere but idle
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    line rate in bit/s
//   The derived TICK_DIV (clocks per oversample tick) must come out >= 1.

module uart_rx_deframer #(
  parameter int unsigned CLK_HZ = 64000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Rounded to the nearest integer divisor.
  localparam int unsigned TICK_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic rxs_q;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      sub_q, sub_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            deliver_q, deliver_d;
  logic            frame_err_q, frame_err_d;
  logic            tick;

  // ---------------------------------------------------------------------------
  // Consumer-facing registers
  // ---------------------------------------------------------------------------
  logic [7:0] dout_q, dout_d;
  logic       rdy_q, rdy_d;
  logic       overrun_q, overrun_d;

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------------
  // The divider is held at zero while idle, so the tick phase is aligned to the
  // detected start edge and every later sample lands at a fixed offset in its bit.
  assign tick = (state_q != StIdle) && (div_q == DivLast);

  always_comb begin
    div_d = div_q;
    if (state_q == StIdle) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Deframing FSM, next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          sub_d   = '0;
          bit_d   = '0;
        end
      end

      StStart: begin
        if (tick) begin
          // The 8th tick falls in the middle of the start bit.
          if (sub_q == 4'd7) begin
            if (rxs_q) begin
              // The line went back high, so this was a glitch. Drop it quietly.
              state_d = StIdle;
            end else begin
              state_d = StData;
              sub_d   = '0;
              bit_d   = '0;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            shift_d[bit_q] = rxs_q;
            sub_d          = '0;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            sub_d = '0;
            if (rxs_q) begin
              // Return to idle at mid stop bit so a back-to-back start edge is caught.
              deliver_d = 1'b1;
              state_d   = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end

      StBreak: begin
        // A held-low line must not re-trigger a start. Wait for it to go high.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Delivery and consumer handshake
  // ---------------------------------------------------------------------------
  // A delivery always wins over a same-cycle rdy_clr. The consumer is then
  // treated as having read the old byte, so overrun stays clear.
  always_comb begin
    dout_d    = dout_q;
    rdy_d     = rdy_q;
    overrun_d = overrun_q;
    if (deliver_q) begin
      dout_d = shift_q;
      rdy_d  = 1'b1;
      if (rdy_q && !rdy_clr) begin
        overrun_d = 1'b1;
      end
    end else if (rdy_clr && rdy_q) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      div_q       <= '0;
      sub_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      dout_q      <= '0;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      div_q       <= div_d;
      sub_q       <= sub_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      dout_q      <= dout_d;
      rdy_q       <= rdy_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer.
// TICK_DIV = 1, so one bit lasts 16 clocks. Expected receive events are queued
// when a frame is issued. A separate monitor pops and compares them whenever
// the DUT presents a byte or a framing error.

module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_fe;
    logic [7:0] data;
    bit         ov;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_deframer #(
    .CLK_HZ(1600000),
    .BAUD  (100000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .dout     (dout),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input bit is_fe, input logic [7:0] data, input bit ov);
    exp_t e;
    e.is_fe = is_fe;
    e.data  = data;
    e.ov    = ov;
    exp_q.push_back(e);
  endtask

  // Starts driving at the current negedge. Afterwards rx stays at the stop level.
  task automatic send_frame(input logic [7:0] data, input bit stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
  endtask

  // Monitor. Events are a frame_err pulse, rdy rising, or dout changing while rdy is set.
  initial begin
    logic       prev_rdy;
    logic [7:0] prev_dout;
    exp_t       e;
    prev_rdy  = 1'b0;
    prev_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err === 1'b1 || (rdy === 1'b1 && (!prev_rdy || dout !== prev_dout))) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event frame_err=%0b rdy=%0b dout=0x%0h required=none t=%0t",
                     frame_err, rdy, dout, $time);
          end else begin
            e = exp_q.pop_front();
            check("event_is_frame_err", {31'd0, frame_err}, {31'd0, e.is_fe});
            if (!e.is_fe) begin
              check("sb_dout", {24'd0, dout}, {24'd0, e.data});
              check("sb_overrun", {31'd0, overrun}, {31'd0, e.ov});
            end
          end
        end
      end
      prev_rdy  = rdy;
      prev_dout = dout;
    end
  end

  initial begin
    // Reset, then an idle line.
    repeat (3) @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'h00);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
        check("idle_outputs", {22'd0, rdy, busy, dout}, 32'h0);
      end else begin
        checks++;
      end
    end

    // 0xA5 with exact latency. rdy must rise 155 edges after the rx fall is sampled.
    push_exp(1'b0, 8'hA5, 1'b0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (155) @(negedge clk);
        check("a5_rdy_before_latency", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        check("a5_rdy_at_latency", {31'd0, rdy}, 32'd1);
        check("a5_dout", {24'd0, dout}, 32'hA5);
      end
    join
    check("a5_rdy_before_clr", {31'd0, rdy}, 32'd1);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    check("a5_rdy_after_clr", {31'd0, rdy}, 32'd0);
    check("a5_dout_held", {24'd0, dout}, 32'hA5);
    repeat (20) @(negedge clk);

    // Back-to-back 0x3C then 0xC3 with no clear, which gives an overrun.
    push_exp(1'b0, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    push_exp(1'b0, 8'hC3, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_dout", {24'd0, dout}, 32'hC3);
    check("ovr_rdy", {31'd0, rdy}, 32'd1);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    check("ovr_rdy_cleared", {31'd0, rdy}, 32'd0);
    check("ovr_overrun_cleared", {31'd0, overrun}, 32'd0);
    repeat (20) @(negedge clk);

    // 0x55 with the stop bit low. Expect a framing error, then break until rx rises.
    push_exp(1'b1, 8'h00, 1'b0);
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    check("fe_busy_while_low", {31'd0, busy}, 32'd1);
    check("fe_rdy", {31'd0, rdy}, 32'd0);
    check("fe_dout_kept", {24'd0, dout}, 32'hC3);
    check("fe_pulse_ended", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("fe_busy_after_high", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // A 5-clock glitch is a false start.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_rdy", {31'd0, rdy}, 32'd0);

    // Reset in the middle of the data bits of 0xFF. The byte must never appear.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreset_dout", {24'd0, dout}, 32'h00);
    check("midreset_rdy", {31'd0, rdy}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (200) @(negedge clk);
    check("abandoned_rdy", {31'd0, rdy}, 32'd0);
    push_exp(1'b0, 8'h12, 1'b0);
    send_frame(8'h12, 1'b1);
    check("x12_dout", {24'd0, dout}, 32'h12);
    check("x12_rdy", {31'd0, rdy}, 32'd1);
    repeat (10) @(negedge clk);

    // 0x6D with rdy_clr on the exact delivery cycle. Delivery wins and there is no overrun.
    push_exp(1'b0, 8'h6D, 1'b0);
    fork
      send_frame(8'h6D, 1'b1);
      begin
        repeat (155) @(negedge clk);
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        check("clr_on_deliv_rdy", {31'd0, rdy}, 32'd1);
        check("clr_on_deliv_dout", {24'd0, dout}, 32'h6D);
        check("clr_on_deliv_overrun", {31'd0, overrun}, 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    check("final_rdy", {31'd0, rdy}, 32'd1);

    // Every queued event must have been observed.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_pending", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receive front end: the upstream stage that feeds the peripheral's instruction-memory loader.
- Synchronises the raw RX pin (ui_in[7]), oversamples at 16x baud, and deframes 8N1 bytes.
- Presents each byte on dout with a sticky rdy flag; the consumer clears the flag with a one-cycle rdy_clr pulse.
- Flags framing errors and overruns for debug readback.

Parameters:
- CLK_HZ, 64000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- TICK_DIV, (CLK_HZ+BAUD*8)/(BAUD*16), derived localparam: clocks per 16x oversample tick (35 at defaults); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  raw asynchronous serial line; idles high.
- rdy_clr  input  1  one-cycle pulse from the consumer; clears rdy and overrun.
- dout  output  8  last correctly received byte.
- rdy  output  1  byte available on dout; sticky until rdy_clr.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; a byte completed while rdy was already set.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (clk edge with rst=1):
  - Outputs: dout=0, rdy=0, frame_err=0, overrun=0, busy=0.
  - Internal: state=IDLE, synchroniser flops=1, tick and bit counters=0.
  - Reset mid-frame abandons the frame; no partial byte is ever delivered.
- Synchroniser: two flops on rx, then rxs. This adds 2 clocks of latency. All decisions use rxs only.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits a one-clock tick at TICK_DIV-1.
  - Held at 0 in IDLE, so the sample phase is aligned to the start edge.
  - A sub-tick counter (0..15) counts ticks within the current bit.
- FSM:
  - IDLE: when rxs=0, go to START and clear the counters.
  - START: on the 8th tick (mid start bit), sample rxs.
    - rxs=1: false start; return to IDLE, no flags.
    - rxs=0: go to DATA, bit index 0, sub-tick 0.
  - DATA: every 16th tick, sample rxs into shift[bit index], LSB first. After bit 7, go to STOP.
  - STOP: on the 16th tick, sample rxs.
    - rxs=1: byte is good; deliver it (see Delivery) and go to IDLE.
    - rxs=0: pulse frame_err for one clock, discard the byte, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Delivery (clock after the stop-sample tick):
  - dout<=shift; rdy<=1.
  - If rdy was already 1 and rdy_clr is not asserted that cycle: overrun<=1. dout is still overwritten with the new byte (newest wins).
  - Delivery and rdy_clr in the same cycle: delivery wins. rdy stays 1, dout holds the new byte, overrun is unchanged (not set).
- rdy_clr with no delivery that cycle: rdy<=0 and overrun<=0.
- rdy_clr while rdy=0: no effect.
- frame_err never changes dout or rdy.
- Latency: from the rx falling edge to rdy rising is 2 (synchroniser) + 8*TICK_DIV + 8*16*TICK_DIV + 16*TICK_DIV + 1 clocks.
- Back-to-back frames are supported: the FSM returns to IDLE at mid stop bit, so the next start edge is caught.

Test Plan:
Bench parameters: CLK_HZ=1600000, BAUD=100000, giving TICK_DIV=1 and 16 clocks per bit.
- Reset then idle line -> rdy=0, busy=0, dout=0x00 for 200 clocks.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) starting at clock 10 -> rdy=1 at clock 10+2+8+128+16+1=165, dout=0xA5, frame_err never pulses. Then rdy_clr at clock 170 -> rdy=0 at 171.
- Frames 0x3C then 0xC3 with no rdy_clr -> after the second: dout=0xC3, rdy=1, overrun=1. Then rdy_clr -> rdy=0, overrun=0.
- Send 0x55 with stop bit forced low -> one-clock frame_err pulse, rdy stays 0, dout keeps its previous value, busy stays 1 until rx returns high.
- rx low for only 5 clocks (glitch) -> FSM returns to IDLE, no rdy, no frame_err.
- rst asserted mid DATA of 0xFF, then a clean 0x12 sent -> no 0xFF delivered, dout=0x12, rdy=1. Also pulse rdy_clr exactly on the delivery cycle of a second byte -> rdy stays 1, overrun=0.
